// File: rtl/cnn_result_buffer.sv
// Result buffer behind the CNN accelerator: packs FP32 results in pairs into a bus-readable RAM.
// Optional ReLU on stored elements is enabled with `define CNN_RELU_EN.
module cnn_result_buffer #(
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_SIZE       = 4096,
  parameter int CNT_WIDTH      = $clog2(MAX_SIZE) + 1
) (
  input  logic                      clkIn,
  input  logic                      rstIn,
  input  logic                      startIn,
  input  logic [CNT_WIDTH-1:0]      numResultsIn,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  input  logic                      validIn,
  output logic                      readyOut,
  input  logic [BUS_ADDR_WIDTH-1:0] addrIn,
  input  logic                      rdEnIn,
  output logic [BUS_DATA_WIDTH-1:0] rdDataOut,
  output logic                      rdAckOut,
  output logic                      doneOut,
  output logic                      errOut,
  output logic [CNT_WIDTH-1:0]      countOut
);

  localparam int DEPTH = MAX_SIZE / 2;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [CNT_WIDTH-1:0]      num_q, num_d;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]     lane_q, lane_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [BUS_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      rd_ack_q, rd_ack_d;

  logic [BUS_DATA_WIDTH-1:0] ram [DEPTH];
  logic                      ram_we;
  logic [BUS_DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0]     elem;
  logic                      xfer;
  logic                      start_err;
  logic [PTR_W-1:0]          rd_idx;
  logic                      unused_addr;

  assign rd_idx      = addrIn[3 +: PTR_W];
  assign unused_addr = ^{addrIn[BUS_ADDR_WIDTH-1:3+PTR_W], addrIn[2:0]};
  assign xfer        = validIn && ready_q;
  assign start_err   = numResultsIn > CNT_WIDTH'(MAX_SIZE);

`ifdef CNN_RELU_EN
  // Any sign-set value (negatives and -0.0) is stored as +0.0.
  assign elem = dataIn[DATA_WIDTH-1] ? '0 : dataIn;
`else
  assign elem = dataIn;
`endif

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    lane_d    = lane_q;
    ready_d   = ready_q;
    done_d    = done_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_wdata = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (startIn) begin
          num_d   = numResultsIn;
          count_d = '0;
          ptr_d   = '0;
          err_d   = start_err;
          if (numResultsIn == '0 || start_err) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            ready_d = 1'b0;
          end else begin
            state_d = ST_COLLECT;
            done_d  = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (xfer) begin
          count_d = count_q + CNT_WIDTH'(1);
          if (!count_q[0]) begin
            lane_d = elem;
          end else begin
            ram_we    = 1'b1;
            ram_wdata = {elem, lane_q};
            ptr_d     = ptr_q + PTR_W'(1);
          end
          // An even-indexed final element is still sitting in the lane register.
          if (count_d == num_q) begin
            ready_d = 1'b0;
            if (!count_q[0]) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        ram_we    = 1'b1;
        ram_wdata = {{(BUS_DATA_WIDTH-DATA_WIDTH){1'b0}}, lane_q};
        ptr_d     = ptr_q + PTR_W'(1);
        state_d   = ST_DONE;
        done_d    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    rd_ack_d  = rdEnIn;
    rd_data_d = rdEnIn ? ram[rd_idx] : rd_data_q;
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      count_q   <= '0;
      ptr_q     <= '0;
      lane_q    <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      lane_q    <= lane_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  // Reset suppresses any write computed from the pre-reset state.
  always_ff @(posedge clkIn) begin
    if (ram_we && !rstIn) begin
      ram[ptr_q] <= ram_wdata;
    end
  end

  assign readyOut  = ready_q;
  assign doneOut   = done_q;
  assign errOut    = err_q;
  assign countOut  = count_q;
  assign rdDataOut = rd_data_q;
  assign rdAckOut  = rd_ack_q;

endmodule

// File: tb/tb_cnn_result_buffer.sv
// Self-checking bench for cnn_result_buffer with a queue-based packing model.
// Compile with +define+CNN_RELU_EN to check the ReLU build.
module tb_cnn_result_buffer;

  logic        clkIn;
  logic        rstIn;
  logic        startIn;
  logic [12:0] numResultsIn;
  logic [31:0] dataIn;
  logic        validIn;
  logic        readyOut;
  logic [31:0] addrIn;
  logic        rdEnIn;
  logic [63:0] rdDataOut;
  logic        rdAckOut;
  logic        doneOut;
  logic        errOut;
  logic [12:0] countOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] stimQ[$];
  logic [63:0] expMem [2048];

  cnn_result_buffer dut (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .numResultsIn(numResultsIn),
    .dataIn(dataIn), .validIn(validIn), .readyOut(readyOut), .addrIn(addrIn),
    .rdEnIn(rdEnIn), .rdDataOut(rdDataOut), .rdAckOut(rdAckOut), .doneOut(doneOut),
    .errOut(errOut), .countOut(countOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef CNN_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  // Expected RAM image: element pairs packed high/low from word 0, odd tail padded with zero.
  task automatic buildModel(input int n);
    for (int k = 0; 2 * k < n; k++) begin
      expMem[k][31:0]  = relu(stimQ[2*k]);
      expMem[k][63:32] = (2 * k + 1 < n) ? relu(stimQ[2*k+1]) : 32'h0;
    end
  endtask

  task automatic startRun(input int n);
    startIn      = 1'b1;
    numResultsIn = 13'(n);
    tick();
    startIn      = 1'b0;
  endtask

  // Streams stimQ[0..n-1], tracking accepts with a model of when the block should be ready.
  task automatic applyStimulus(input int n, input bit rndValid);
    int  idx    = 0;
    int  budget = 0;
    bit  hs;
    while (idx < n && budget < 40 * n + 100) begin
      validIn = rndValid ? 1'($urandom_range(0, 1)) : 1'b1;
      dataIn  = stimQ[idx];
      checkOutput("ready_model", 64'(readyOut), 64'(idx < n));
      hs = validIn && (idx < n);
      tick();
      budget++;
      if (hs) idx++;
      checkOutput("count_track", 64'(countOut), 64'(idx));
      if (idx < n) checkOutput("done_low_in_run", 64'(doneOut), 64'd0);
    end
    validIn = 1'b0;
    checkOutput("all_accepted", 64'(idx), 64'(n));
    checkOutput("ready_low_after_last", 64'(readyOut), 64'd0);
    checkOutput("done_latency_1", 64'(doneOut), 64'(n % 2 == 0));
    if (n % 2 == 1) begin
      tick();
      checkOutput("done_latency_2", 64'(doneOut), 64'd1);
    end
    validIn = 1'b1;
    dataIn  = $urandom;
    tick();
    tick();
    validIn = 1'b0;
    checkOutput("no_extra_accepts", 64'(countOut), 64'(n));
    checkOutput("done_held", 64'(doneOut), 64'd1);
    checkOutput("err_clear", 64'(errOut), 64'd0);
    buildModel(n);
  endtask

  task automatic readWord(input string tag, input logic [31:0] addr, input logic [63:0] exp);
    rdEnIn = 1'b1;
    addrIn = addr;
    tick();
    rdEnIn = 1'b0;
    addrIn = $urandom;
    checkOutput({tag, "_ack"}, 64'(rdAckOut), 64'd1);
    checkOutput(tag, rdDataOut, exp);
    tick();
    checkOutput({tag, "_ack_drop"}, 64'(rdAckOut), 64'd0);
    checkOutput({tag, "_hold"}, rdDataOut, exp);
  endtask

  // Reads every written word with random ignored address bits above and below the index.
  task automatic checkRun(input int n);
    logic [31:0] a;
    for (int k = 0; 2 * k < n; k++) begin
      a = ($urandom & 32'hFFFF_C000) | (32'(k) << 3) | 32'($urandom_range(0, 7));
      readWord("ram_word", a, expMem[k]);
    end
  endtask

  initial begin
    logic [63:0] oldWord;
    logic [31:0] va, vb;
    int          n;

    clkIn = 1'b0; rstIn = 1'b1; startIn = 1'b0; numResultsIn = '0;
    dataIn = '0; validIn = 1'b0; addrIn = '0; rdEnIn = 1'b0;
    $display("[TB] reset and idle");
    repeat (3) tick();
    rstIn = 1'b0;
    repeat (5) tick();
    checkOutput("rst_ready", 64'(readyOut), 64'd0);
    checkOutput("rst_done", 64'(doneOut), 64'd0);
    checkOutput("rst_ack", 64'(rdAckOut), 64'd0);
    checkOutput("rst_count", 64'(countOut), 64'd0);
    checkOutput("rst_err", 64'(errOut), 64'd0);
    checkOutput("rst_rddata", rdDataOut, 64'd0);

    $display("[TB] four elements, valid held");
    stimQ = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    startRun(4);
    checkOutput("start_ready", 64'(readyOut), 64'd1);
    checkOutput("start_done_clear", 64'(doneOut), 64'd0);
    applyStimulus(4, 1'b0);
    readWord("t2_word0", 32'h0, 64'h40000000_3F800000);
    readWord("t2_word1", 32'h8, 64'h40800000_40400000);

    $display("[TB] three elements, random valid");
    stimQ = '{32'h3F800000, 32'h40000000, 32'h40400000};
    startRun(3);
    applyStimulus(3, 1'b1);
    readWord("t3_word1", 32'h8, 64'h00000000_40400000);
    readWord("t3_word0_wrap", 32'h0001_0000 | 32'(2048 << 3), 64'h40000000_3F800000);

    $display("[TB] random runs");
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 40);
      stimQ = {};
      for (int i = 0; i < n; i++) stimQ.push_back($urandom);
      startRun(n);
      applyStimulus(n, 1'b1);
      checkRun(n);
    end

    $display("[TB] zero and oversized runs");
    startRun(0);
    checkOutput("zero_done", 64'(doneOut), 64'd1);
    checkOutput("zero_ready", 64'(readyOut), 64'd0);
    checkOutput("zero_err", 64'(errOut), 64'd0);
    checkOutput("zero_count", 64'(countOut), 64'd0);
    startRun(4097);
    checkOutput("big_err", 64'(errOut), 64'd1);
    checkOutput("big_done", 64'(doneOut), 64'd1);
    validIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("big_ready_low", 64'(readyOut), 64'd0);
      tick();
    end
    validIn = 1'b0;
    checkOutput("big_count", 64'(countOut), 64'd0);
    startRun(4096);
    checkOutput("max_err_clear", 64'(errOut), 64'd0);
    checkOutput("max_ready", 64'(readyOut), 64'd1);

    $display("[TB] start ignored mid-run, then reset abort");
    rstIn = 1'b1;
    tick();
    rstIn = 1'b0;
    stimQ = {};
    for (int i = 0; i < 6; i++) stimQ.push_back($urandom);
    startRun(6);
    validIn = 1'b1;
    dataIn  = stimQ[0];
    tick();
    dataIn  = stimQ[1];
    tick();
    validIn = 1'b0;
    checkOutput("mid_count", 64'(countOut), 64'd2);
    startRun(1);
    checkOutput("mid_start_ignored_count", 64'(countOut), 64'd2);
    checkOutput("mid_start_ignored_ready", 64'(readyOut), 64'd1);
    checkOutput("mid_start_ignored_done", 64'(doneOut), 64'd0);
    rstIn = 1'b1;
    tick();
    rstIn = 1'b0;
    repeat (3) tick();
    checkOutput("abort_ready", 64'(readyOut), 64'd0);
    checkOutput("abort_count", 64'(countOut), 64'd0);
    checkOutput("abort_done", 64'(doneOut), 64'd0);
    stimQ = '{32'h11111111, 32'h22222222};
    startRun(2);
    applyStimulus(2, 1'b0);
    readWord("t5_word0", 32'h0, 64'h22222222_11111111);

    $display("[TB] sign handling");
    stimQ = '{32'hBF800000, 32'h3F800000};
    startRun(2);
    applyStimulus(2, 1'b0);
`ifdef CNN_RELU_EN
    oldWord = 64'h3F800000_00000000;
`else
    oldWord = 64'h3F800000_BF800000;
`endif
    readWord("t6_word0", 32'h0, oldWord);
    stimQ = '{32'h80000000, 32'hC0000000, 32'h40000000};
    startRun(3);
    applyStimulus(3, 1'b1);
`ifdef CNN_RELU_EN
    readWord("t6_negzero", 32'h0, 64'h00000000_00000000);
`else
    readWord("t6_negzero", 32'h0, 64'hC0000000_80000000);
`endif
    readWord("t6_tail", 32'h8, 64'h00000000_40000000);
    oldWord = expMem[0];

    $display("[TB] read-first on concurrent write");
    va = $urandom;
    vb = $urandom;
    startRun(2);
    validIn = 1'b1;
    dataIn  = va;
    tick();
    dataIn  = vb;
    rdEnIn  = 1'b1;
    addrIn  = 32'h0;
    tick();
    validIn = 1'b0;
    rdEnIn  = 1'b0;
    checkOutput("rf_old_data", rdDataOut, oldWord);
    checkOutput("rf_ack", 64'(rdAckOut), 64'd1);
    checkOutput("rf_done", 64'(doneOut), 64'd1);
    readWord("rf_new_data", 32'h0, {relu(vb), relu(va)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
